// File: rtl/stream_reduce_checker_if.sv
// Handshake bundle for stream_reduce_checker: beat input stream plus the registered frame summary.
interface stream_reduce_checker_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_par;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic             m_and;
  logic             m_or;
  logic             m_xor;
  logic [CW-1:0]    m_beats;
  logic             m_par_err;
  logic             m_len_err;
  logic [15:0]      err_count;

  modport slave (
    input  s_valid, s_data, s_par, s_last, m_ready,
    output s_ready, m_valid, m_and, m_or, m_xor, m_beats, m_par_err, m_len_err, err_count
  );

  modport master (
    output s_valid, s_data, s_par, s_last, m_ready,
    input  s_ready, m_valid, m_and, m_or, m_xor, m_beats, m_par_err, m_len_err, err_count
  );
endinterface

// File: rtl/stream_reduce_checker.sv
// Per-frame parity checker and AND/OR/XOR reducer with a held, registered summary.
// Optional macro STREAM_REDUCE_ERR_COUNT_EN enables a saturating count of errored frames.
module stream_reduce_checker #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  stream_reduce_checker_if.slave   bus
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_ready;
  logic             r_valid;
  logic [WIDTH-1:0] r_acc_and;
  logic [WIDTH-1:0] r_acc_or;
  logic [WIDTH-1:0] r_acc_xor;
  logic [CW-1:0]    r_cnt;
  logic             r_perr;
  logic             r_lerr;
  logic             r_and;
  logic             r_or;
  logic             r_xor;
  logic [CW-1:0]    r_beats;
  logic             r_par_err;
  logic             r_len_err;

  logic             w_accept;
  logic             w_beat_perr;
  logic             w_cnt_full;
  logic [CW-1:0]    w_cnt_inc;

  assign w_accept    = bus.s_valid && r_ready;
  assign w_beat_perr = (^bus.s_data) ^ bus.s_par;
  assign w_cnt_full  = (r_cnt == MAX_CNT);
  assign w_cnt_inc   = w_cnt_full ? r_cnt : r_cnt + 1'b1;

  // NOTE: default assignment first so every path drives w_next_state and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, ACCUM: if (w_accept) w_next_state = bus.s_last ? HOLD : ACCUM;
      HOLD:        if (bus.m_ready) w_next_state = IDLE;
      default:     w_next_state = IDLE;
    endcase
  end

  // s_ready and m_valid are registered copies of the next state, so s_ready
  // is low during reset and never depends combinationally on m_ready.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state != HOLD);
      r_valid <= (w_next_state == HOLD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_and <= '1;
      r_acc_or  <= '0;
      r_acc_xor <= '0;
      r_cnt     <= '0;
      r_perr    <= 1'b0;
      r_lerr    <= 1'b0;
    end else if (w_accept) begin
      if (bus.s_last) begin
        r_acc_and <= '1;
        r_acc_or  <= '0;
        r_acc_xor <= '0;
        r_cnt     <= '0;
        r_perr    <= 1'b0;
        r_lerr    <= 1'b0;
      end else begin
        r_acc_and <= r_acc_and & bus.s_data;
        r_acc_or  <= r_acc_or  | bus.s_data;
        r_acc_xor <= r_acc_xor ^ bus.s_data;
        r_cnt     <= w_cnt_inc;
        r_perr    <= r_perr | w_beat_perr;
        r_lerr    <= r_lerr | w_cnt_full;
      end
    end
  end

  // Summary registers load only on the last beat and otherwise hold through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_and     <= 1'b0;
      r_or      <= 1'b0;
      r_xor     <= 1'b0;
      r_beats   <= '0;
      r_par_err <= 1'b0;
      r_len_err <= 1'b0;
    end else if (w_accept && bus.s_last) begin
      r_and     <= &(r_acc_and & bus.s_data);
      r_or      <= |(r_acc_or | bus.s_data);
      r_xor     <= ^(r_acc_xor ^ bus.s_data);
      r_beats   <= w_cnt_inc;
      r_par_err <= r_perr | w_beat_perr;
      r_len_err <= r_lerr | w_cnt_full;
    end
  end

`ifdef STREAM_REDUCE_ERR_COUNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (r_valid && bus.m_ready && (r_par_err || r_len_err) &&
                 (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign bus.err_count = r_err_count;
`else
  assign bus.err_count = '0;
`endif

  assign bus.s_ready   = r_ready;
  assign bus.m_valid   = r_valid;
  assign bus.m_and     = r_and;
  assign bus.m_or      = r_or;
  assign bus.m_xor     = r_xor;
  assign bus.m_beats   = r_beats;
  assign bus.m_par_err = r_par_err;
  assign bus.m_len_err = r_len_err;
endmodule

// File: tb/tb_stream_reduce_checker.sv
// Scoreboard bench for stream_reduce_checker: frames are modelled when driven, summaries checked on output.
module tb_stream_reduce_checker;
  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 16;

  typedef struct {
    logic a;
    logic o;
    logic x;
    int   beats;
    logic pe;
    logic le;
  } exp_t;

  logic clk;
  logic rst_n;

  stream_reduce_checker_if #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) bus ();

  stream_reduce_checker #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_err = 0;
  exp_t exp_q[$];
  logic [WIDTH-1:0] fr_d[$];
  logic             fr_p[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 0);
    check({tag, "_m_valid"}, 32'(bus.m_valid), 0);
    check({tag, "_outs"}, {26'd0, bus.m_and, bus.m_or, bus.m_xor, bus.m_par_err, bus.m_len_err, 1'b0}, 0);
    check({tag, "_m_beats"}, 32'(bus.m_beats), 0);
    check({tag, "_err_count"}, 32'(bus.err_count), 0);
  endtask

  // Reference model over the frame currently held in fr_d/fr_p.
  task automatic push_model();
    exp_t e;
    logic [WIDTH-1:0] a = '1;
    logic [WIDTH-1:0] o = '0;
    logic [WIDTH-1:0] x = '0;
    logic pe = 1'b0;
    for (int i = 0; i < fr_d.size(); i++) begin
      a  = a & fr_d[i];
      o  = o | fr_d[i];
      x  = x ^ fr_d[i];
      pe = pe | ((^fr_d[i]) ^ fr_p[i]);
    end
    e.a     = &a;
    e.o     = |o;
    e.x     = ^x;
    e.beats = (fr_d.size() > MAX_BEATS) ? MAX_BEATS : fr_d.size();
    e.pe    = pe;
    e.le    = (fr_d.size() > MAX_BEATS);
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic drive_beat(input logic [WIDTH-1:0] d, input logic p, input logic l);
    int w = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_par   = p;
    bus.s_last  = l;
    while (!bus.s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.s_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame();
    for (int i = 0; i < fr_d.size(); i++) begin
      if (i > 0) check("s_ready_accum", 32'(bus.s_ready), 1);
      drive_beat(fr_d[i], fr_p[i], (i == fr_d.size() - 1));
    end
    bus.s_valid = 1'b0;
    push_model();
  endtask

  // Checks the summary one cycle after the last beat, holds it for `hold` cycles, then accepts it.
  task automatic collect(input int hold);
    exp_t e;
    check("latency_m_valid", 32'(bus.m_valid), 1);
    if (exp_q.size() == 0) begin
      check("sb_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    for (int c = 0; c <= hold; c++) begin
      check("hold_s_ready", 32'(bus.s_ready), 0);
      check("hold_m_valid", 32'(bus.m_valid), 1);
      check("m_and", 32'(bus.m_and), 32'(e.a));
      check("m_or", 32'(bus.m_or), 32'(e.o));
      check("m_xor", 32'(bus.m_xor), 32'(e.x));
      check("m_beats", 32'(bus.m_beats), 32'(e.beats));
      check("m_par_err", 32'(bus.m_par_err), 32'(e.pe));
      check("m_len_err", 32'(bus.m_len_err), 32'(e.le));
      if (c < hold) @(negedge clk);
    end
    bus.m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.m_ready = 1'b0;
`ifdef STREAM_REDUCE_ERR_COUNT_EN
    if (e.pe || e.le) exp_err++;
`endif
    check("release_m_valid", 32'(bus.m_valid), 0);
    check("release_s_ready", 32'(bus.s_ready), 1);
    check("err_count", 32'(bus.err_count), 32'(exp_err));
  endtask

  task automatic load(input logic [WIDTH-1:0] d, input logic p);
    fr_d.push_back(d);
    fr_p.push_back(p);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_par   = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_s_ready", 32'(bus.s_ready), 1);

    // Single all-ones beat.
    fr_d = {}; fr_p = {};
    load(8'hFF, 1'b0);
    send_frame();
    collect(0);

    // Three beats, correct parity, then with a parity error on beat 2.
    fr_d = {}; fr_p = {};
    load(8'h0F, 1'b0); load(8'hF0, 1'b0); load(8'h01, 1'b1);
    send_frame();
    collect(0);
    fr_p[1] = 1'b1;
    send_frame();
    collect(0);

    // Length boundaries: exactly MAX_BEATS, then MAX_BEATS+1 and +2 beats.
    for (int n = MAX_BEATS; n <= MAX_BEATS + 2; n++) begin
      fr_d = {}; fr_p = {};
      for (int i = 0; i < n; i++) load(8'h00, 1'b0);
      send_frame();
      collect(0);
    end

    // Backpressure: summary held 5 cycles while a new beat waits upstream.
    fr_d = {}; fr_p = {};
    load(8'hAA, 1'b0);
    send_frame();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h3C;
    bus.s_par   = 1'b0;
    bus.s_last  = 1'b1;
    collect(5);
    fr_d = {}; fr_p = {};
    load(8'h3C, 1'b0);
    push_model();
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    collect(0);

    // Random frames, occasional parity errors.
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(1, MAX_BEATS + 3);
      fr_d = {}; fr_p = {};
      for (int i = 0; i < n; i++) begin
        logic [WIDTH-1:0] d;
        d = WIDTH'($urandom);
        load(d, (^d) ^ ($urandom_range(0, 9) == 0));
      end
      send_frame();
      collect($urandom_range(0, 2));
    end

    // Reset mid-frame discards the partial frame.
    drive_beat(8'h55, 1'b0, 1'b0);
    drive_beat(8'h01, 1'b0, 1'b0);
    bus.s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_err = 0;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    check("release_s_ready_low", 32'(bus.s_ready), 0);
    @(posedge clk);
    @(negedge clk);
    fr_d = {}; fr_p = {};
    load(8'h80, 1'b1);
    send_frame();
    collect(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
